// File: rtl/lstm_decoder_seq.sv
// Decoder-side sequencer: drives an external LSTM cell for SEQ_LEN steps, projects each
// new hidden state through a serial MAC (HIDDEN->1) and streams the samples out.
module lstm_decoder_seq #(
    parameter int DATA_WIDTH     = 32,
    parameter int FRACT_WIDTH    = 24,
    parameter int HIDDEN_SIZE    = 10,
    parameter int SEQ_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] z_in,
    input  logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] w_out,
    input  logic [DATA_WIDTH-1:0]                  b_out,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   error,
    output logic                                   cell_start,
    output logic [DATA_WIDTH-1:0]                  cell_x,
    output logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] cell_h_prev,
    output logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] cell_c_prev,
    input  logic                                   cell_done,
    input  logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] cell_h_out,
    input  logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] cell_c_out,
    output logic                                   y_valid,
    input  logic                                   y_ready,
    output logic [DATA_WIDTH-1:0]                  y_data,
    output logic                                   y_last
);

    localparam int AW = 2 * DATA_WIDTH;
    localparam int KW = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;
    localparam int SW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, CELL_START, CELL_WAIT, CAPTURE, PROJ, EMIT, FINISH
    } state_t;

    state_t state, state_next;

    logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] h_q, c_q;
    logic [DATA_WIDTH-1:0]                  x_q;
    logic [SW-1:0]                          step;
    logic [KW-1:0]                          k;
    logic [TW-1:0]                          tcnt;
    logic signed [AW-1:0]                   acc;

    logic signed [AW-1:0]   w_ext, h_ext, prod, acc_next;
    logic [DATA_WIDTH-1:0]  y_next;
    logic                   is_last, k_last, tcnt_expired;

    assign is_last      = (step == SW'(SEQ_LEN - 1));
    assign k_last       = (k == KW'(HIDDEN_SIZE - 1));
    assign tcnt_expired = (tcnt == TW'(TIMEOUT_CYCLES - 1));

    assign cell_x      = x_q;
    assign cell_h_prev = h_q;
    assign cell_c_prev = c_q;

    // Each term is shifted back to Q-format before accumulation, so fractional
    // residue is floored per product rather than once at the end.
    always_comb begin
        w_ext    = {{DATA_WIDTH{w_out[k][DATA_WIDTH-1]}}, w_out[k]};
        h_ext    = {{DATA_WIDTH{h_q[k][DATA_WIDTH-1]}}, h_q[k]};
        prod     = w_ext * h_ext;
        acc_next = acc + (prod >>> FRACT_WIDTH);
        y_next   = acc_next[DATA_WIDTH-1:0] + b_out;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every comb output gets a default before the case so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (start) state_next = LOAD;
            LOAD:       state_next = CELL_START;
            CELL_START: if (!cell_done) state_next = CELL_WAIT;
            CELL_WAIT: begin
                if (cell_done)         state_next = CAPTURE;
                else if (tcnt_expired) state_next = FINISH;
            end
            CAPTURE:    state_next = PROJ;
            PROJ:       if (k_last) state_next = EMIT;
            EMIT:       if (y_ready) state_next = is_last ? FINISH : CELL_START;
            FINISH:     state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // cell_start is gated by cell_done so a level left over from the previous step is never mistaken for completion.
    always_comb begin
        busy       = (state != IDLE);
        done       = (state == FINISH);
        cell_start = (state == CELL_START) && !cell_done;
        y_valid    = (state == EMIT);
        y_last     = (state == EMIT) && is_last;
    end

    // NOTE: the h/c state banks are cleared on reset as well, so an aborted run
    // never leaks its hidden state onto cell_h_prev/cell_c_prev.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q    <= '0;
            c_q    <= '0;
            x_q    <= '0;
            step   <= '0;
            k      <= '0;
            tcnt   <= '0;
            acc    <= '0;
            y_data <= '0;
            error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        h_q   <= z_in;
                        c_q   <= '0;
                        x_q   <= '0;
                        step  <= '0;
                        error <= 1'b0;
                    end
                end
                CELL_START: tcnt <= '0;
                CELL_WAIT: begin
                    if (!cell_done) begin
                        tcnt <= tcnt + TW'(1);
                        if (tcnt_expired) error <= 1'b1;
                    end
                end
                CAPTURE: begin
                    h_q <= cell_h_out;
                    c_q <= cell_c_out;
                    acc <= '0;
                    k   <= '0;
                end
                PROJ: begin
                    acc <= acc_next;
                    k   <= k + KW'(1);
                    if (k_last) y_data <= y_next;
                end
                EMIT: begin
                    if (y_ready) begin
                        x_q <= y_data;
                        if (!is_last) step <= step + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_decoder_seq.sv
// Directed bench for lstm_decoder_seq with an identity LSTM cell stub
// (HIDDEN_SIZE=2, SEQ_LEN=3, TIMEOUT_CYCLES=50).
module tb_lstm_decoder_seq;

    localparam int DW = 32;
    localparam int HS = 2;
    localparam int SL = 3;
    localparam int TO = 50;

    logic                   clk = 1'b0;
    logic                   rst, start, cell_done, y_ready;
    logic [HS-1:0][DW-1:0]  z_in, w_out, cell_h_prev, cell_c_prev, cell_h_out, cell_c_out;
    logic [DW-1:0]          b_out, cell_x, y_data;
    logic                   busy, done, error, cell_start, y_valid, y_last;

    lstm_decoder_seq #(
        .DATA_WIDTH(DW), .FRACT_WIDTH(24), .HIDDEN_SIZE(HS),
        .SEQ_LEN(SL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .z_in(z_in), .w_out(w_out), .b_out(b_out),
        .busy(busy), .done(done), .error(error), .cell_start(cell_start),
        .cell_x(cell_x), .cell_h_prev(cell_h_prev), .cell_c_prev(cell_c_prev),
        .cell_done(cell_done), .cell_h_out(cell_h_out), .cell_c_out(cell_c_out),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] z0, z1, w0, w1, b, y;
    } vec_t;
    vec_t vecs[5];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Identity cell stub: returns h/c unchanged, raises cell_done stub_lat cycles
    // after cell_start and keeps it high for stub_hold cycles.
    int   stub_lat  = 5;
    int   stub_hold = 1;
    logic stub_never = 1'b0;
    logic stub_run;
    int   stub_cnt, hold_cnt;

    assign cell_h_out = cell_h_prev;
    assign cell_c_out = cell_c_prev;

    always @(posedge clk) begin
        if (rst) begin
            stub_run  <= 1'b0;
            stub_cnt  <= 0;
            hold_cnt  <= 0;
            cell_done <= 1'b0;
        end else if (cell_start && !stub_never) begin
            stub_run <= 1'b1;
            stub_cnt <= 1;
        end else if (stub_run) begin
            if (stub_cnt >= stub_lat) begin
                stub_run  <= 1'b0;
                cell_done <= 1'b1;
                hold_cnt  <= stub_hold;
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end else if (hold_cnt > 1) begin
            hold_cnt <= hold_cnt - 1;
        end else begin
            hold_cnt  <= 0;
            cell_done <= 1'b0;
        end
    end

    int                   cs_count, done_count;
    logic [DW-1:0]        cx_log[$], y_log[$];
    logic                 last_log[$];
    logic [HS*DW-1:0]     h_log[$], c_log[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (cell_start) begin
                cs_count++;
                cx_log.push_back(cell_x);
                h_log.push_back(cell_h_prev);
                c_log.push_back(cell_c_prev);
                check("cell_start_while_cell_done", 64'(cell_done), 64'd0);
                check("cell_start_while_y_valid", 64'(y_valid), 64'd0);
            end
            if (done) done_count++;
            if (y_valid && y_ready) begin
                y_log.push_back(y_data);
                last_log.push_back(y_last);
            end
        end
    end

    task automatic load_vec(input vec_t v);
        z_in  = {v.z1, v.z0};
        w_out = {v.w1, v.w0};
        b_out = v.b;
    endtask

    task automatic clear_logs();
        cs_count   = 0;
        done_count = 0;
        cx_log.delete();
        y_log.delete();
        last_log.delete();
        h_log.delete();
        c_log.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Checks a completed 3-step run against one vector: beats, last flags, feedback and h/c.
    task automatic check_run(input string tag, input vec_t v);
        check({tag, "_beats"}, 64'(y_log.size()), 64'(SL));
        check({tag, "_cell_starts"}, 64'(cs_count), 64'(SL));
        for (int j = 0; j < SL; j++) begin
            if (j < y_log.size()) begin
                check($sformatf("%s_y%0d", tag, j), 64'(y_log[j]), 64'(v.y));
                check($sformatf("%s_last%0d", tag, j), 64'(last_log[j]), 64'(j == SL - 1));
            end
            if (j < cx_log.size()) begin
                check($sformatf("%s_x%0d", tag, j), 64'(cx_log[j]), (j == 0) ? 64'd0 : 64'(v.y));
                check($sformatf("%s_h%0d", tag, j), 64'(h_log[j]), {v.z1, v.z0});
                check($sformatf("%s_c%0d", tag, j), 64'(c_log[j]), 64'd0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          got;
        logic [DW-1:0] yd;
        int            cs0, dc0, lat;

        // {z0, z1, w0, w1, b, expected y}
        vecs[0] = '{32'h0100_0000, 32'h0100_0000, 32'h0040_0000, 32'h0040_0000, 32'h0080_0000, 32'h0100_0000};
        vecs[1] = '{32'h0100_0000, 32'h0100_0000, 32'h0000_0000, 32'h0000_0000, 32'h0020_0000, 32'h0020_0000};
        vecs[2] = '{32'hFF00_0000, 32'h0200_0000, 32'h0180_0000, 32'hFFC0_0000, 32'h0000_0000, 32'hFE00_0000};
        vecs[3] = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0003, 32'hFFFF_FFFD, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[4] = '{32'h7F00_0000, 32'h7F00_0000, 32'h0200_0000, 32'h0100_0000, 32'h0100_0000, 32'h7E00_0000};

        rst = 1'b1; start = 1'b0; y_ready = 1'b1;
        z_in = '0; w_out = '0; b_out = '0;
        clear_logs();

        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_y_valid", 64'(y_valid), 64'd0);
        check("rst_y_data", 64'(y_data), 64'd0);
        check("rst_cell_start", 64'(cell_start), 64'd0);
        check("rst_h", cell_h_prev, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Reset asserted mid-PROJ aborts the run with no done pulse
        load_vec(vecs[0]);
        clear_logs();
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cell_done) begin
                got = 1'b1;
                break;
            end
        end
        check("abort_cell_done_seen", 64'(got), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        dc0 = done_count;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_y_valid", 64'(y_valid), 64'd0);
        check("abort_cell_start", 64'(cell_start), 64'd0);
        check("abort_x", 64'(cell_x), 64'd0);
        check("abort_h", cell_h_prev, 64'd0);
        check("abort_c", cell_c_prev, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_done", 64'(done_count), 64'(dc0));
        check("abort_idle", 64'(busy), 64'd0);

        // Table-driven full runs with identity cell and feedback
        for (int i = 0; i < 5; i++) begin
            load_vec(vecs[i]);
            clear_logs();
            pulse_start();
            wait_done(500, got);
            check($sformatf("v%0d_done", i), 64'(got), 64'd1);
            check($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'd1);
            check($sformatf("v%0d_error", i), 64'(error), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_busy_after", i), 64'(busy), 64'd0);
            check($sformatf("v%0d_done_pulses", i), 64'(done_count), 64'd1);
            check_run($sformatf("v%0d", i), vecs[i]);
        end

        // Backpressure: hold y_ready low for 20 cycles at the first sample
        load_vec(vecs[0]);
        clear_logs();
        y_ready = 1'b0;
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (y_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("bp_valid_seen", 64'(got), 64'd1);
        yd  = y_data;
        cs0 = cs_count;
        check("bp_first_y", 64'(yd), 64'(vecs[0].y));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_y_valid_held", 64'(y_valid), 64'd1);
            check("bp_y_data_stable", 64'(y_data), 64'(yd));
        end
        check("bp_no_cell_start", 64'(cs_count), 64'(cs0));
        @(posedge clk); #1 y_ready = 1'b1;
        wait_done(500, got);
        check("bp_done", 64'(got), 64'd1);
        @(negedge clk);
        check_run("bp", vecs[0]);

        // Timeout: cell never completes
        clear_logs();
        stub_never = 1'b1;
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cell_start) begin
                got = 1'b1;
                break;
            end
        end
        check("to_cell_start_seen", 64'(got), 64'd1);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check("to_latency", 64'(lat), 64'd51);
        check("to_error_at_done", 64'(error), 64'd1);
        stub_never = 1'b0;
        @(negedge clk);
        check("to_error_sticky", 64'(error), 64'd1);
        check("to_no_beats", 64'(y_log.size()), 64'd0);
        check("to_one_cell_start", 64'(cs_count), 64'd1);

        // A new accepted start clears the sticky error and the run completes
        load_vec(vecs[1]);
        clear_logs();
        pulse_start();
        @(negedge clk);
        check("to_error_cleared", 64'(error), 64'd0);
        check("to_restart_busy", 64'(busy), 64'd1);
        wait_done(500, got);
        check("to_restart_done", 64'(got), 64'd1);
        check("to_restart_error", 64'(error), 64'd0);
        @(negedge clk);
        check_run("to_restart", vecs[1]);

        // Stale done: cell_done stays high well past CAPTURE/PROJ/EMIT
        stub_hold = 8;
        load_vec(vecs[2]);
        clear_logs();
        pulse_start();
        wait_done(500, got);
        check("stale_done", 64'(got), 64'd1);
        check("stale_error", 64'(error), 64'd0);
        @(negedge clk);
        check_run("stale", vecs[2]);
        stub_hold = 1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
